mem_access_unit: RTL and testbench

//  MEM-stage initiator for the word-wide, single-port data memory (1-cycle registered read, no byte enables).

---
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide single-port data memory with a 1-cycle registered read.
// Handles byte/half/word loads and stores, using read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 32,
  parameter int N_ELEMENTS = 128,
  parameter int ADDRWIDTH  = $clog2(N_ELEMENTS)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 load_i,
  input  logic                 store_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [NB_ADDR-1:0]   addr_i,
  input  logic [NB_DATA-1:0]   store_data_i,
  output logic [NB_DATA-1:0]   load_data_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 busy_o,
  output logic                 mem_enable_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [NB_DATA-1:0]   mem_wdata_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  input  logic [NB_DATA-1:0]   mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE, ERR} state_t;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] word_addr;
  logic [1:0]           offset;
  logic [1:0]           size;
  logic                 uns;
  logic                 is_load;
  logic [NB_DATA-1:0]   wdata;
  logic [NB_DATA-1:0]   load_data;
  logic                 bad;
  logic [4:0]           byte_sh, half_sh;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [NB_DATA-1:0]   ext, merged;

  always_comb begin
    bad = (load_i == store_i) || (size_i == 2'b11) ||
          (size_i == 2'b01 && addr_i[0]) ||
          (size_i == 2'b10 && addr_i[1:0] != 2'b00) ||
          ((addr_i >> (ADDRWIDTH + 2)) != '0);
  end

  // Little-endian lanes: byte k at bits [8k+7:8k], half at [15:0] or [31:16].
  always_comb begin
    byte_sh = {offset, 3'b000};
    half_sh = {offset[1], 4'b0000};
    lane_b  = mem_rdata_i[byte_sh +: 8];
    lane_h  = mem_rdata_i[half_sh +: 16];
    ext     = mem_rdata_i;
    merged  = mem_rdata_i;
    case (size)
      2'b00: begin
        ext = {{(NB_DATA-8){~uns & lane_b[7]}}, lane_b};
        merged[byte_sh +: 8] = wdata[7:0];
      end
      2'b01: begin
        ext = {{(NB_DATA-16){~uns & lane_h[15]}}, lane_h};
        merged[half_sh +: 16] = wdata[15:0];
      end
      default: begin
        ext    = mem_rdata_i;
        merged = wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) begin
        if (bad)                  state_nxt = ERR;
        else if (load_i)          state_nxt = RD_ISSUE;
        else if (size_i == 2'b10) state_nxt = WR;
        else                      state_nxt = RD_ISSUE;
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = is_load ? DONE : WR;
      WR:       state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      word_addr <= '0;
      offset    <= '0;
      size      <= '0;
      uns       <= 1'b0;
      is_load   <= 1'b0;
      wdata     <= '0;
      load_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i) begin
        word_addr <= addr_i[ADDRWIDTH+1:2];
        offset    <= addr_i[1:0];
        size      <= size_i;
        uns       <= unsigned_i;
        is_load   <= load_i;
        wdata     <= store_data_i;
        load_data <= '0;
      end else if (state == RD_WAIT) begin
        // Read word is either the load result or the merge base for WR.
        if (is_load) load_data <= ext;
        else         wdata     <= merged;
      end
    end
  end

  assign load_data_o  = load_data;
  assign done_o       = (state == DONE) || (state == ERR);
  assign error_o      = (state == ERR);
  assign busy_o       = (state != IDLE);
  assign mem_read_o   = (state == RD_ISSUE);
  assign mem_write_o  = (state == WR);
  assign mem_enable_o = mem_read_o || mem_write_o;
  assign mem_addr_o   = mem_enable_o ? word_addr : '0;
  assign mem_wdata_o  = mem_write_o ? wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a word-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, load, store, uns;
  logic [1:0]  size;
  logic [31:0] addr, sdata;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic        done, error, busy, mem_en, mem_rd, mem_wr;
  logic [6:0]  mem_addr;

  logic [31:0] ram     [128];
  logic [31:0] ref_ram [128];
  int n_chk = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, exp_done = 0;
  logic [6:0] last_addr;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .load_i(load), .store_i(store),
    .size_i(size), .unsigned_i(uns), .addr_i(addr), .store_data_i(sdata),
    .load_data_o(load_data), .done_o(done), .error_o(error), .busy_o(busy),
    .mem_enable_o(mem_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_rd), .mem_write_o(mem_wr), .mem_rdata_i(mem_rdata)
  );

  // Word-wide single-port RAM with registered read.
  always @(posedge clk) begin
    if (mem_en && mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_en && mem_wr) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rw_excl", {31'b0, mem_rd & mem_wr}, 32'd0);
      chk("en_strobe", {31'b0, mem_en}, {31'b0, mem_rd | mem_wr});
      if (!mem_en) chk("idle_bus", {25'b0, mem_addr} | mem_wdata, 32'd0);
    end
    if (mem_rd) begin n_rd++; last_addr = mem_addr; end
    if (mem_wr) begin n_wr++; last_addr = mem_addr; end
    if (done) n_done++;
  end

  task automatic setw(input int i, input logic [31:0] v);
    ram[i] = v;
    ref_ram[i] = v;
  endtask

  // Issue one request at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] sd, input bit noise);
    int idx, off, lat, exp_lat, exp_rd, exp_wr, rd0, wr0;
    logic err;
    logic [31:0] w, v, mask, exp_ld;
    idx = int'(a >> 2) & 127;
    off = int'(a & 32'd3);
    err = (ld == st) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && (a & 32'd3) != 0) || ((a >> 9) != 0);
    exp_ld = 32'd0;
    exp_rd = 0;
    exp_wr = 0;
    w = ref_ram[idx];
    if (err) exp_lat = 1;
    else if (ld) begin
      exp_lat = 3; exp_rd = 1;
      if (sz == 2'd0) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (!un && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (!un && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else v = w;
      exp_ld = v;
    end else begin
      exp_wr = 1;
      if (sz == 2'd2) begin exp_lat = 2; ref_ram[idx] = sd; end
      else begin
        exp_lat = 4; exp_rd = 1;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_ram[idx] = (w & ~mask) | ((sd << (8 * off)) & mask);
      end
    end
    rd0 = n_rd; wr0 = n_wr;
    start = 1'b1; load = ld; store = st; size = sz; uns = un; addr = a; sdata = sd;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    while (!done && lat < 12) begin
      if (noise) begin
        start = 1'b1; load = $urandom; store = $urandom; size = $urandom;
        uns = $urandom; addr = $urandom; sdata = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    exp_done++;
    chk("latency", lat, exp_lat);
    chk("error", {31'b0, error}, {31'b0, err});
    chk("load_data", load_data, exp_ld);
    chk("reads", n_rd - rd0, exp_rd);
    chk("writes", n_wr - wr0, exp_wr);
    if (!err) chk("mem_addr", {25'b0, last_addr}, idx);
    if (!err && st) chk("ram_word", ram[idx], ref_ram[idx]);
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("ld_hold", load_data, exp_ld);
    chk("done_count", n_done, exp_done);
  endtask

  initial begin
    int rd0, wr0;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        ld;
    rst_n = 1'b0; start = 1'b0; load = 1'b0; store = 1'b0; size = 2'd0;
    uns = 1'b0; addr = 32'd0; sdata = 32'd0;
    for (int i = 0; i < 128; i++) setw(i, $urandom);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {30'b0, done, error}, 32'd0);
    chk("rst_mem", {28'b0, mem_en, mem_rd, mem_wr, 1'b0} | mem_wdata | {25'b0, mem_addr}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    setw(1, 32'h00F00301);
    do_req(1, 0, 2'd2, 0, 32'h4, 0, 0);
    chk("lw4", load_data, 32'h00F00301);

    setw(0, 32'h00F00C01);
    do_req(1, 0, 2'd0, 0, 32'h1, 0, 0); chk("lb1", load_data, 32'h0000000C);
    do_req(1, 0, 2'd0, 0, 32'h2, 0, 0); chk("lb2", load_data, 32'hFFFFFFF0);
    do_req(1, 0, 2'd0, 1, 32'h2, 0, 0); chk("lbu2", load_data, 32'h000000F0);
    do_req(1, 0, 2'd1, 0, 32'h2, 0, 0); chk("lh2", load_data, 32'h000000F0);

    setw(4, 32'h00000004);
    do_req(0, 1, 2'd0, 0, 32'h11, 32'h000000AB, 0); chk("sb11", ram[4], 32'h0000AB04);
    do_req(0, 1, 2'd1, 0, 32'h12, 32'h0000BEEF, 0); chk("sh12", ram[4], 32'hBEEFAB04);

    do_req(0, 1, 2'd1, 0, 32'h3, 32'h1234, 0);
    do_req(1, 0, 2'd2, 0, 32'h6, 0, 0);
    do_req(1, 0, 2'd2, 0, 32'h200, 0, 0);
    do_req(1, 1, 2'd2, 0, 32'h8, 0, 0);
    do_req(1, 0, 2'd3, 0, 32'h8, 0, 0);

    // Reset during RD_WAIT of a byte store must abort without any write.
    rd0 = n_rd; wr0 = n_wr;
    start = 1'b1; load = 1'b0; store = 1'b1; size = 2'd0; uns = 1'b0;
    addr = 32'h11; sdata = 32'h55;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_bus", {29'b0, mem_en, mem_rd, mem_wr}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_ld", load_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_reads", n_rd - rd0, 1);
    chk("abort_writes", n_wr - wr0, 0);
    chk("abort_ram", ram[4], 32'hBEEFAB04);
    n_done = 0; exp_done = 0;
    do_req(1, 0, 2'd2, 0, 32'h4, 0, 0);
    chk("post_rst_lw", load_data, 32'h00F00301);

    // Random traffic; some requests see start_i pulsed while busy.
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) sz = 2'd3;
      a = {23'b0, 7'($urandom), 2'b00};
      if (sz == 2'd0) a = a | 32'($urandom_range(0, 3));
      if (sz == 2'd1) a = a | (32'($urandom_range(0, 1)) << 1);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
      ld = $urandom;
      if ($urandom_range(0, 19) == 0) do_req(ld, ld, sz, $urandom, a, $urandom, $urandom_range(0, 3) == 0);
      else do_req(ld, ~ld, sz, $urandom, a, $urandom, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 128; i++)
      if (ram[i] !== ref_ram[i]) chk("final_ram", ram[i], ref_ram[i]);
    chk("final_ram_w0", ram[0], ref_ram[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
